// File: rtl/fifo_pkg.sv
// Shared definitions for the ASYNC_FIFO read-side blocks: state encodings,
// default widths shared with the FIFO, and counter sizing.
package fifo_pkg;

   localparam int DEF_DATA_WIDTH    = 8;
   localparam int DEF_ADDRESS_WIDTH = 4;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } rd_state_t;

   // Bits needed to represent every value in 0..n inclusive.
   function automatic int lane_idx_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/rd_idle_timer.sv
// Saturating idle counter. The timeout output is high while the count sits one
// below LIMIT, so the owner can act on the LIMIT-th idle cycle.
module rd_idle_timer
   import fifo_pkg::*;
#(
   parameter int LIMIT = 16,
   parameter int CW    = lane_idx_width(LIMIT)
) (
   input  logic CLK,
   input  logic RST,
   input  logic clr,
   input  logic en,
   output logic timeout
);

   logic [CW-1:0] idle_cnt;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         idle_cnt <= '0;
      end else if (clr) begin
         idle_cnt <= '0;
      end else if (en && (idle_cnt != CW'(LIMIT))) begin
         idle_cnt <= idle_cnt + CW'(1);
      end
   end

   assign timeout = (idle_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-side consumer for ASYNC_FIFO: pops show-ahead entries and packs
// PACK_RATIO of them into one valid/ready output word, flushing partial words.
module fifo_rd_packer
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int PACK_RATIO     = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                             CLK,
   input  logic                             RST,
   input  logic                             EMPTY,
   input  logic [DATA_WIDTH-1:0]            Rd_data,
   output logic                             R_INC,
   input  logic                             FLUSH,
   output logic [DATA_WIDTH*PACK_RATIO-1:0] OUT_DATA,
   output logic [PACK_RATIO-1:0]            OUT_BE,
   output logic                             OUT_VALID,
   input  logic                             OUT_READY,
   output rd_state_t                        dbg_state
);

   localparam int CW = lane_idx_width(PACK_RATIO);

   // Output handshake: a word transfers on a CLK edge where OUT_VALID and
   // OUT_READY are both high; OUT_VALID never drops and OUT_DATA/OUT_BE never
   // change until that transfer happens.

   rd_state_t                             state;
   rd_state_t                             state_nxt;
   logic [CW-1:0]                         count;
   logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] lanes;
   logic                                  pop;
   logic                                  accept;
   logic                                  has_data;
   logic                                  last_lane;
   logic                                  timeout;
   logic                                  flush_trig;
   logic                                  go_hold;
   logic                                  idle_clr;
   logic                                  idle_en;

   // Popping only in COLLECT guarantees no entry is taken while a word waits.
   assign pop        = RST & ~EMPTY & (state == COLLECT);
   assign R_INC      = pop;
   assign OUT_VALID  = (state == HOLD);
   assign accept     = OUT_VALID & OUT_READY;
   assign has_data   = (count != '0);
   assign last_lane  = (count == CW'(PACK_RATIO - 1));
   assign flush_trig = FLUSH | (timeout & has_data);
   assign OUT_DATA   = lanes;
   assign dbg_state  = state;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= COLLECT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      go_hold   = 1'b0;
      case (state)
         COLLECT: begin
            if ((pop && last_lane) || (flush_trig && (has_data || pop))) begin
               state_nxt = HOLD;
               go_hold   = 1'b1;
            end
         end
         HOLD: begin
            if (accept) begin
               state_nxt = COLLECT;
            end
         end
         default: state_nxt = COLLECT;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         count  <= '0;
         lanes  <= '0;
         OUT_BE <= '0;
      end else if (accept) begin
         count  <= '0;
         lanes  <= '0;
         OUT_BE <= '0;
      end else if (pop) begin
         for (int i = 0; i < PACK_RATIO; i++) begin
            if (count == CW'(i)) begin
               lanes[i]  <= Rd_data;
               OUT_BE[i] <= 1'b1;
            end
         end
         count <= count + CW'(1);
      end
   end

   // Idle time only accumulates while a partial word is waiting for more data.
   assign idle_clr = pop | ~has_data | go_hold;
   assign idle_en  = (state == COLLECT) & has_data & ~pop;

   rd_idle_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_idle_timer (
      .CLK     (CLK),
      .RST     (RST),
      .clr     (idle_clr),
      .en      (idle_en),
      .timeout (timeout)
   );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a queue-based show-ahead FIFO feeds the packer, a
// word-level model predicts packed words, and a monitor checks them on accept.
module tb_fifo_rd_packer;
   import fifo_pkg::*;

   localparam int DW    = 8;
   localparam int PR    = 4;
   localparam int TO    = 16;
   localparam int OW    = DW * PR;
   localparam int DEPTH = 16;
   localparam int HALF  = 10;

   logic            CLK = 1'b0;
   logic            RST = 1'b0;
   logic            EMPTY = 1'b1;
   logic [DW-1:0]   Rd_data = '0;
   logic            R_INC;
   logic            FLUSH = 1'b0;
   logic [OW-1:0]   OUT_DATA;
   logic [PR-1:0]   OUT_BE;
   logic            OUT_VALID;
   logic            OUT_READY = 1'b1;
   rd_state_t       dbg_state;

   logic            wr_en = 1'b0;
   logic [DW-1:0]   wr_val = '0;

   logic [DW-1:0]   fifo_q[$];
   logic [DW-1:0]   cur[$];
   logic [OW+PR-1:0] exp_q[$];
   int              idle;
   bit              hold;
   logic [OW-1:0]   held_data;
   logic [PR-1:0]   held_be;
   int              checks;
   int              errors;
   int              words_seen;
   int              words_exp;

   fifo_rd_packer #(
      .DATA_WIDTH     (DW),
      .PACK_RATIO     (PR),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .EMPTY     (EMPTY),
      .Rd_data   (Rd_data),
      .R_INC     (R_INC),
      .FLUSH     (FLUSH),
      .OUT_DATA  (OUT_DATA),
      .OUT_BE    (OUT_BE),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #HALF CLK = ~CLK;

   initial begin
      #(HALF * 2 * 20000);
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic bound_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got wait expired expected condition within budget", name);
   endtask

   // Concatenate entries: first entry lands in the low lane, unused lanes stay 0.
   function automatic logic [OW+PR-1:0] pack(input logic [DW-1:0] q[$]);
      logic [OW-1:0] d = '0;
      logic [PR-1:0] be = '0;
      foreach (q[i]) begin
         d[i*DW +: DW] = q[i];
         be[i] = 1'b1;
      end
      return {be, d};
   endfunction

   // ---------------- FIFO model + reference model ----------------
   always begin : env
      bit               do_pop;
      bit               do_wr;
      bit               tmo;
      logic [DW-1:0]    wv;
      logic [OW+PR-1:0] w;
      @(negedge CLK);
      #(HALF - 1);
      do_pop = R_INC;
      do_wr  = wr_en;
      wv     = wr_val;
      if (!RST) begin
         check("rst_r_inc", R_INC, 0);
         check("rst_valid", OUT_VALID, 0);
         check("rst_be", OUT_BE, 0);
         check("rst_data", OUT_DATA, 0);
         words_exp = words_exp - exp_q.size();
         exp_q.delete();
         cur.delete();
         idle = 0;
         hold = 0;
      end else begin
         check("out_valid", OUT_VALID, hold);
         check("dbg_state", (dbg_state == HOLD), hold);
         if (hold) begin
            check("r_inc_in_hold", R_INC, 0);
            check("held_data", OUT_DATA, held_data);
            check("held_be", OUT_BE, held_be);
            if (OUT_READY) hold = 0;
         end else begin
            w = pack(cur);
            check("partial_data", OUT_DATA, w[OW-1:0]);
            check("partial_be", OUT_BE, w[OW+PR-1:OW]);
            check("r_inc", R_INC, (fifo_q.size() > 0));
            tmo = (cur.size() > 0) && (idle == TO - 1);
            if (R_INC && fifo_q.size() > 0) begin
               cur.push_back(fifo_q[0]);
               idle = 0;
            end else if (cur.size() > 0) begin
               idle++;
            end
            if (cur.size() == PR || (cur.size() > 0 && (FLUSH || tmo))) begin
               w = pack(cur);
               exp_q.push_back(w);
               words_exp++;
               held_data = w[OW-1:0];
               held_be   = w[OW+PR-1:OW];
               hold      = 1;
               cur.delete();
               idle      = 0;
            end
         end
      end
      @(posedge CLK);
      #1;
      if (do_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (do_wr) fifo_q.push_back(wv);
      EMPTY   = (fifo_q.size() == 0);
      Rd_data = EMPTY ? '0 : fifo_q[0];
   end

   // ---------------- monitor / scoreboard ----------------
   always begin : monitor
      logic [OW+PR-1:0] e;
      @(negedge CLK);
      #(HALF - 1);
      if (RST && OUT_VALID && OUT_READY) begin
         words_seen++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got data %h be %h expected no word", OUT_DATA, OUT_BE);
         end else begin
            e = exp_q.pop_front();
            check("word_data", OUT_DATA, e[OW-1:0]);
            check("word_be", OUT_BE, e[OW+PR-1:OW]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic write_byte(input logic [DW-1:0] b);
      int guard = 0;
      while (fifo_q.size() >= DEPTH && guard < 500) begin
         @(negedge CLK);
         guard++;
      end
      if (guard >= 500) bound_fail("fifo_space_wait");
      wr_en  = 1'b1;
      wr_val = b;
      @(negedge CLK);
      wr_en  = 1'b0;
   endtask

   task automatic write_list(input logic [DW-1:0] bytes[$]);
      foreach (bytes[i]) write_byte(bytes[i]);
   endtask

   task automatic wait_cur(input int n);
      int guard = 0;
      while (cur.size() != n && guard < 100) begin
         @(negedge CLK);
         guard++;
      end
      if (guard >= 100) bound_fail("partial_fill_wait");
   endtask

   task automatic pulse_flush();
      FLUSH = 1'b1;
      @(negedge CLK);
      FLUSH = 1'b0;
   endtask

   task automatic drain(input string name);
      int guard = 0;
      while ((fifo_q.size() != 0 || cur.size() != 0 || hold || exp_q.size() != 0) && guard < 300) begin
         @(negedge CLK);
         guard++;
      end
      if (guard >= 300) bound_fail(name);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [DW-1:0] bl[$];
      checks = 0;
      errors = 0;
      words_seen = 0;
      words_exp = 0;
      idle = 0;
      hold = 0;

      // Reset, with an entry arriving in the FIFO while reset is held.
      tick(2);
      write_byte(8'h5A);
      tick(2);
      RST = 1'b1;
      drain("drain_after_reset");

      // Full word.
      bl = '{8'hAF, 8'h47, 8'h1F, 8'h04};
      write_list(bl);
      drain("drain_s1");
      check("empty_after_s1", EMPTY, 1);

      // Two full words then a timeout-flushed partial.
      bl = '{8'hAF, 8'h47, 8'h1F, 8'h04, 8'hFF, 8'h16, 8'h14, 8'h98, 8'h23, 8'hF0};
      write_list(bl);
      drain("drain_s2");

      // Back-pressure: downstream stalls while the FIFO fills.
      OUT_READY = 1'b0;
      for (int i = 0; i < 16; i++) write_byte(DW'(8'h30 + i));
      tick(40);
      OUT_READY = 1'b1;
      drain("drain_s3");

      // Explicit flush of a single entry, then a flush with nothing held.
      write_byte(8'hAF);
      wait_cur(1);
      tick(3);
      pulse_flush();
      tick(3);
      pulse_flush();
      tick(5);
      drain("drain_s4");

      // Flush coinciding with the second pop.
      bl = '{8'hAF, 8'h47};
      write_list(bl);
      wait_cur(1);
      pulse_flush();
      drain("drain_s5");

      // Asynchronous reset in the middle of a word.
      bl = '{8'h55, 8'h66};
      write_list(bl);
      wait_cur(2);
      check("be_before_reset", OUT_BE, 4'h3);
      RST = 1'b0;
      #1;
      check("async_rst_valid", OUT_VALID, 0);
      check("async_rst_be", OUT_BE, 0);
      check("async_rst_data", OUT_DATA, 0);
      tick(2);
      RST = 1'b1;
      bl = '{8'h11, 8'h22, 8'h33, 8'h44};
      write_list(bl);
      drain("drain_s6");

      // Randomized traffic with random back-pressure and flushes.
      repeat (400) begin
         OUT_READY = ($urandom_range(0, 3) != 0);
         FLUSH     = ($urandom_range(0, 19) == 0);
         if (fifo_q.size() < DEPTH - 1 && $urandom_range(0, 9) < 6) begin
            wr_en  = 1'b1;
            wr_val = DW'($urandom_range(0, 255));
         end else begin
            wr_en  = 1'b0;
         end
         @(negedge CLK);
      end
      wr_en     = 1'b0;
      FLUSH     = 1'b0;
      OUT_READY = 1'b1;
      drain("drain_random");

      tick(4);
      check("scoreboard_empty", exp_q.size(), 0);
      check("word_count", words_seen, words_exp);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
